// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its debug dump controller.
// Default geometry is 32 registers of 32 bits each. The dump state
// machine has two states and uses a one-bit encoding.
package regfile_pkg;

    localparam int NBITS = 32;
    localparam int RBITS = 5;
    localparam int NREGS = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Debug dump sequencer for the register file.
//
// The sequencer walks every register index exactly once, starting at 0,
// and offers one beat per index with a valid/ready handshake.
//
// Register contents are read through a peek port. peek_idx names the
// index that will be captured at the next clock edge, so dump_data always
// holds the stored value from before that edge. If a write to the same
// index lands on that edge, the captured beat keeps the old value.
module regfile_dump_ctrl #(
    parameter int NBITS = regfile_pkg::NBITS,
    parameter int RBITS = regfile_pkg::RBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dump_start,
    input  logic             dump_ready,
    input  logic [NBITS-1:0] peek_data,
    output logic [RBITS-1:0] peek_idx,
    output logic             dump_valid,
    output logic [RBITS-1:0] dump_idx,
    output logic [NBITS-1:0] dump_data,
    output logic             dump_busy
);
    import regfile_pkg::*;

    localparam logic [RBITS-1:0] LAST_IDX = {RBITS{1'b1}};

    dump_state_t      state, state_next;
    logic [RBITS-1:0] idx, idx_next;
    logic [NBITS-1:0] data, data_next;

    // State, beat index and captured beat data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            data  <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            data  <= data_next;
        end
    end

    // Next-state logic. A transfer happens on every SEND cycle with
    // dump_ready high, because dump_valid is high for the whole SEND state.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        data_next  = data;
        peek_idx   = idx + RBITS'(1);
        case (state)
            IDLE: begin
                peek_idx = '0;
                if (dump_start) begin
                    state_next = SEND;
                    idx_next   = '0;
                    data_next  = peek_data;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (idx == LAST_IDX) begin
                        state_next = IDLE;
                        idx_next   = '0;
                        data_next  = '0;
                    end else begin
                        idx_next  = idx + RBITS'(1);
                        data_next = peek_data;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
                data_next  = '0;
            end
        endcase
    end

    assign dump_valid = (state == SEND);
    assign dump_busy  = (state == SEND);
    assign dump_idx   = idx;
    assign dump_data  = data;

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file. Index 0 is hard-wired to zero.
// Reads are combinational. Writes happen on the rising edge of clk.
// A debug dump port streams every register out through regfile_dump_ctrl.
//
// Optional feature, enabled by defining REGFILE_BYPASS_EN:
//   A write in progress is forwarded straight to any read port that
//   addresses the same nonzero index in the same cycle.
module register_file #(
    parameter int NBITS = regfile_pkg::NBITS,
    parameter int RBITS = regfile_pkg::RBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RBITS-1:0] reg_rs,
    input  logic [RBITS-1:0] reg_rt,
    output logic [NBITS-1:0] data_rs,
    output logic [NBITS-1:0] data_rt,
    input  logic             wr_en,
    input  logic [RBITS-1:0] wr_reg,
    input  logic [NBITS-1:0] wr_data,
    input  logic             dump_start,
    input  logic             dump_ready,
    output logic             dump_valid,
    output logic [RBITS-1:0] dump_idx,
    output logic [NBITS-1:0] dump_data,
    output logic             dump_busy
);
    import regfile_pkg::*;

    localparam int DEPTH = 1 << RBITS;

    logic [NBITS-1:0] regs [DEPTH];
    logic [NBITS-1:0] stored_rs;
    logic [NBITS-1:0] stored_rt;
    logic [RBITS-1:0] peek_idx;
    logic [NBITS-1:0] peek_data;
    logic             wr_live;

    assign wr_live = wr_en && (wr_reg != '0);

    // Storage array. Index 0 is never written, so it always holds zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_reg] <= wr_data;
        end
    end

    // Stored-value lookup for both read ports, with index 0 forced to zero
    always_comb begin
        stored_rs = (reg_rs == '0) ? '0 : regs[reg_rs];
        stored_rt = (reg_rt == '0) ? '0 : regs[reg_rt];
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write to any port that addresses the same index
    always_comb begin
        data_rs = (wr_live && (wr_reg == reg_rs)) ? wr_data : stored_rs;
        data_rt = (wr_live && (wr_reg == reg_rt)) ? wr_data : stored_rt;
    end
`else
    // Read ports return the stored value only
    always_comb begin
        data_rs = stored_rs;
        data_rt = stored_rt;
    end
`endif

    // The dump port always sees the stored value from before the edge
    always_comb begin
        peek_data = (peek_idx == '0) ? '0 : regs[peek_idx];
    end

    regfile_dump_ctrl #(
        .NBITS(NBITS),
        .RBITS(RBITS)
    ) u_dump_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .dump_start(dump_start),
        .dump_ready(dump_ready),
        .peek_data (peek_data),
        .peek_idx  (peek_idx),
        .dump_valid(dump_valid),
        .dump_idx  (dump_idx),
        .dump_data (dump_data),
        .dump_busy (dump_busy)
    );

endmodule
